// File: rtl/fade_pkg.sv
// Shared fade-state codes and colour-wheel segment table for the RGB fade datapath.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fade_pkg;

    // Per-channel fade state code driven into each fade/PWM channel.
    typedef enum logic [1:0] {
        PWM_INC  = 2'b00,
        PWM_DEC  = 2'b01,
        ON_HOLD  = 2'b10,
        OFF_HOLD = 2'b11
    } fade_state_t;

    // The wheel always has six segments; this is a property of the hue
    // table below and is not meant to be changed.
    localparam int NUM_SEGMENTS = 6;

    typedef enum logic [2:0] {
        SEG0 = 3'd0,
        SEG1 = 3'd1,
        SEG2 = 3'd2,
        SEG3 = 3'd3,
        SEG4 = 3'd4,
        SEG5 = 3'd5
    } seg_t;

    // Codes for all three channels, packed {r, g, b}.
    typedef struct packed {
        fade_state_t r;
        fade_state_t g;
        fade_state_t b;
    } rgb_codes_t;

    // Colour-wheel table: each channel leads the next by two segments (120 deg).
    function automatic rgb_codes_t seg_codes(input seg_t seg);
        rgb_codes_t codes;
        case (seg)
            SEG0:    codes = '{r: ON_HOLD,  g: PWM_INC,  b: OFF_HOLD};
            SEG1:    codes = '{r: PWM_DEC,  g: ON_HOLD,  b: OFF_HOLD};
            SEG2:    codes = '{r: OFF_HOLD, g: ON_HOLD,  b: PWM_INC};
            SEG3:    codes = '{r: OFF_HOLD, g: PWM_DEC,  b: ON_HOLD};
            SEG4:    codes = '{r: PWM_INC,  g: OFF_HOLD, b: ON_HOLD};
            SEG5:    codes = '{r: ON_HOLD,  g: OFF_HOLD, b: PWM_DEC};
            default: codes = '{r: ON_HOLD,  g: PWM_INC,  b: OFF_HOLD};
        endcase
        return codes;
    endfunction

    // Successor segment; the unused encodings 6/7 collapse to SEG0 so the
    // wheel can never lock up outside the table.
    function automatic seg_t seg_next(input seg_t seg);
        seg_t nxt;
        case (seg)
            SEG0:    nxt = SEG1;
            SEG1:    nxt = SEG2;
            SEG2:    nxt = SEG3;
            SEG3:    nxt = SEG4;
            SEG4:    nxt = SEG5;
            default: nxt = SEG0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divides clk by INTERVAL: free-running counter that emits a registered one-cycle tick per wrap.
// Latency: tick is high in the cycle after the counter reaches INTERVAL-1; wrap is the same-cycle combinational view.
// Backpressure: enable=0 freezes the counter and forces tick low; clear (like rst) zeroes counter and tick.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   enable       - count when high, hold when low
//   clear        - synchronous restart of the divider (lower priority than rst)
//   tick         - registered one-cycle pulse, one per INTERVAL enabled cycles
//   wrap         - high in the cycle whose edge wraps the counter (lets the owner advance in step with tick)
module tick_gen #(
    parameter int INTERVAL = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick,
    output logic wrap
);

    // Keep at least one bit so INTERVAL=1 still elaborates.
    localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(INTERVAL - 1);

    logic [TW-1:0] r_cnt;
    logic          r_tick;

    assign wrap = enable && !clear && (r_cnt == CNT_LAST);
    assign tick = r_tick;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else if (enable) begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/fade_sequencer.sv
// Colour-wheel controller: steps R/G/B fade state codes through six equal segments with 120 deg channel offset.
// Latency: segment, codes and seg_start all update on the edge that completes INC_DEC_INTERVAL*INC_DEC_MAX enabled cycles.
// Backpressure: enable=0 freezes every counter and output, pulses forced low; restart returns to segment 0 like rst.
// Ports:
//   clk, rst              - system clock (12 MHz), synchronous active-high reset
//   enable                - run / freeze the whole sequence
//   restart               - one-cycle request to go back to segment 0 without a reset (ignores enable)
//   r_state/g_state/b_state - registered fade state codes for the three channels
//   segment               - current wheel segment 0..5
//   step_tick             - one-cycle pulse per fade step
//   seg_start             - one-cycle pulse in the first cycle of each new segment
module fade_sequencer
    import fade_pkg::*;
#(
    parameter int INC_DEC_INTERVAL = 12000,
    parameter int INC_DEC_MAX      = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       restart,
    output logic [1:0] r_state,
    output logic [1:0] g_state,
    output logic [1:0] b_state,
    output logic [2:0] segment,
    output logic       step_tick,
    output logic       seg_start
);

    localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_MAX - 1);

    // Registered state
    logic [SW-1:0] r_step_cnt;
    seg_t          r_seg;
    rgb_codes_t    r_codes;
    logic          r_seg_start;

    // Next-state
    logic [SW-1:0] w_step_cnt_nxt;
    seg_t          w_seg_nxt;
    rgb_codes_t    w_codes_nxt;
    logic          w_seg_start_nxt;

    logic          w_wrap;
    seg_t          w_seg_adv;

    // restart reuses the divider's clear so the fade-step phase restarts
    // together with the segment counter.
    tick_gen #(
        .INTERVAL (INC_DEC_INTERVAL)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (restart),
        .tick   (step_tick),
        .wrap   (w_wrap)
    );

    assign w_seg_adv = seg_next(r_seg);

    always_comb begin
        w_step_cnt_nxt  = r_step_cnt;
        w_seg_nxt       = r_seg;
        w_codes_nxt     = r_codes;
        w_seg_start_nxt = 1'b0;

        if (restart) begin
            // Beats a coincident segment wrap, and never pulses seg_start.
            w_step_cnt_nxt = '0;
            w_seg_nxt      = SEG0;
            w_codes_nxt    = seg_codes(SEG0);
        end else if (w_wrap) begin
            // w_wrap is already qualified by enable.
            if (r_step_cnt == STEP_LAST) begin
                w_step_cnt_nxt  = '0;
                w_seg_nxt       = w_seg_adv;
                // Codes are registered from the table alongside the segment,
                // so they change on exactly the same edge.
                w_codes_nxt     = seg_codes(w_seg_adv);
                w_seg_start_nxt = 1'b1;
            end else begin
                w_step_cnt_nxt = r_step_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt  <= '0;
            r_seg       <= SEG0;
            r_codes     <= seg_codes(SEG0);
            r_seg_start <= 1'b0;
        end else begin
            r_step_cnt  <= w_step_cnt_nxt;
            r_seg       <= w_seg_nxt;
            r_codes     <= w_codes_nxt;
            r_seg_start <= w_seg_start_nxt;
        end
    end

    assign r_state   = r_codes.r;
    assign g_state   = r_codes.g;
    assign b_state   = r_codes.b;
    assign segment   = r_seg;
    assign seg_start = r_seg_start;

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer with small timing parameters.
// Reference: expected outputs derived from a count of enabled cycles since the last reset/restart.
// Directed phases from the test plan followed by randomized enable/restart/rst traffic.
module tb_fade_sequencer;

    localparam int IV      = 4;
    localparam int MX      = 3;
    localparam int SEG_LEN = IV * MX;
    localparam int REV     = 6 * SEG_LEN;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] r_state;
    logic [1:0] g_state;
    logic [1:0] b_state;
    logic [2:0] segment;
    logic       step_tick;
    logic       seg_start;

    fade_sequencer #(
        .INC_DEC_INTERVAL (IV),
        .INC_DEC_MAX      (MX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .restart   (restart),
        .r_state   (r_state),
        .g_state   (g_state),
        .b_state   (b_state),
        .segment   (segment),
        .step_tick (step_tick),
        .seg_start (seg_start)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int   elapsed  = 0;   // enabled cycles since last reset/restart
    bit   en_edge  = 0;   // last edge was a counting edge
    bit   model_ok = 0;   // set once a reset has been applied
    int   starts   = 0;   // observed seg_start pulses
    logic [5:0] exp_tbl [6]; // {r,g,b} codes per segment

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge.
    task automatic cycle(input logic a_rst, input logic a_restart, input logic a_en);
        int         seg_idx;
        logic [5:0] codes;
        rst     = a_rst;
        restart = a_restart;
        enable  = a_en;
        @(posedge clk);
        if (a_rst || a_restart) begin
            elapsed  = 0;
            en_edge  = 0;
            model_ok = 1;
        end else if (a_en) begin
            elapsed++;
            en_edge = 1;
        end else begin
            en_edge = 0;
        end
        @(negedge clk);
        if (seg_start === 1'b1) starts++;
        if (model_ok) begin
            seg_idx = (elapsed / SEG_LEN) % 6;
            codes   = exp_tbl[seg_idx];
            chk_val("segment",   32'(segment),   32'(seg_idx));
            chk_val("r_state",   32'(r_state),   32'(codes[5:4]));
            chk_val("g_state",   32'(g_state),   32'(codes[3:2]));
            chk_val("b_state",   32'(b_state),   32'(codes[1:0]));
            chk_val("step_tick", 32'(step_tick), 32'(en_edge && (elapsed % IV == 0)));
            chk_val("seg_start", 32'(seg_start), 32'(en_edge && (elapsed % SEG_LEN == 0)));
        end
    endtask

    initial begin
        // ON=10 INC=00 OFF=11 DEC=01
        exp_tbl[0] = 6'b10_00_11;
        exp_tbl[1] = 6'b01_10_11;
        exp_tbl[2] = 6'b11_10_00;
        exp_tbl[3] = 6'b11_01_10;
        exp_tbl[4] = 6'b00_11_10;
        exp_tbl[5] = 6'b10_11_01;

        // Reset held two cycles.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);

        // One full revolution: exactly six seg_start pulses.
        starts = 0;
        repeat (REV) cycle(1'b0, 1'b0, 1'b1);
        chk_val("rev_seg_starts", 32'(starts), 32'd6);

        // Freeze for 10 cycles in the middle of segment 2.
        for (int i = 0; i < REV && (elapsed % REV) != 2 * SEG_LEN + 5; i++)
            cycle(1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0);

        // Restart on the edge that would wrap segment 5 back to 0.
        for (int i = 0; i < REV && (elapsed % REV) != REV - 1; i++)
            cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (SEG_LEN + 2) cycle(1'b0, 1'b0, 1'b1);

        // Reset at cycle 7 of segment 3.
        for (int i = 0; i < REV && (elapsed % REV) != 3 * SEG_LEN + 7; i++)
            cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        repeat (2 * SEG_LEN) cycle(1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cycle(r < 2, (r >= 2) && (r < 5), $urandom_range(0, 9) < 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
